// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, stall counter and optional skid buffer.
// Define PIPE_SKID_EN to compile in the skid register and make o_ready a pure register output.
module pipe_stage_reg #(
  parameter int CTRL_W   = 9,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int REG_W    = 5,
  parameter int NUM_REG  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [CTRL_W-1:0]          i_ctrl,
  input  logic [DATA_W*NUM_DATA-1:0] i_data,
  input  logic [REG_W*NUM_REG-1:0]   i_regs,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [CTRL_W-1:0]          o_ctrl,
  output logic [DATA_W*NUM_DATA-1:0] o_data,
  output logic [REG_W*NUM_REG-1:0]   o_regs,
  input  logic                       i_flush,
  input  logic                       i_clr_cnt,
  output logic [CNT_W-1:0]           o_stall_cnt
);

  localparam int DW = DATA_W * NUM_DATA;
  localparam int RW = REG_W * NUM_REG;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic              vld_p0;
  logic              ld_in;
  logic [CTRL_W-1:0] m_ctrl_p0;
  logic [DW-1:0]     m_data_p0;
  logic [RW-1:0]     m_regs_p0;
  logic [CNT_W-1:0]  stall_cnt_q;

`ifdef PIPE_SKID_EN
  logic              ld_s, ld_from_s;
  logic              s_vld_p0;
  logic [CTRL_W-1:0] s_ctrl_p0;
  logic [DW-1:0]     s_data_p0;
  logic [RW-1:0]     s_regs_p0;
`endif

  assign vld_p0 = (state_q != EMPTY);

  always_comb begin
    state_d = state_q;
    ld_in   = 1'b0;
`ifdef PIPE_SKID_EN
    ld_s      = 1'b0;
    ld_from_s = 1'b0;
`endif
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (i_valid) begin
          ld_in   = 1'b1;
          state_d = FULL;
        end
        FULL: begin
          if (i_ready) begin
            if (i_valid) ld_in = 1'b1;
            else         state_d = EMPTY;
          end
`ifdef PIPE_SKID_EN
          else if (i_valid) begin
            ld_s    = 1'b1;
            state_d = SKID;
          end
          // Without the skid buffer o_ready is low here, so the input simply waits.
`endif
        end
`ifdef PIPE_SKID_EN
        SKID: if (i_ready) begin
          ld_from_s = 1'b1;
          state_d   = FULL;
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Main register p0: ctrl is zeroed on every return to EMPTY so bubbles are inert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl_p0 <= '0;
      m_data_p0 <= '0;
      m_regs_p0 <= '0;
    end else if (ld_in) begin
      m_ctrl_p0 <= i_ctrl;
      m_data_p0 <= i_data;
      m_regs_p0 <= i_regs;
    end
`ifdef PIPE_SKID_EN
    else if (ld_from_s) begin
      m_ctrl_p0 <= s_ctrl_p0;
      m_data_p0 <= s_data_p0;
      m_regs_p0 <= s_regs_p0;
    end
`endif
    else if (state_d == EMPTY) begin
      m_ctrl_p0 <= '0;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid register p0: holds the entry accepted while downstream stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld_p0  <= 1'b0;
      s_ctrl_p0 <= '0;
      s_data_p0 <= '0;
      s_regs_p0 <= '0;
    end else if (i_flush) begin
      s_vld_p0  <= 1'b0;
      s_ctrl_p0 <= '0;
    end else if (ld_s) begin
      s_vld_p0  <= 1'b1;
      s_ctrl_p0 <= i_ctrl;
      s_data_p0 <= i_data;
      s_regs_p0 <= i_regs;
    end else if (ld_from_s) begin
      s_vld_p0  <= 1'b0;
    end
  end

  assign o_ready = !s_vld_p0;
`else
  assign o_ready = !vld_p0 || i_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     stall_cnt_q <= '0;
    else if (i_clr_cnt)          stall_cnt_q <= '0;
    else if (vld_p0 && !i_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign o_valid     = vld_p0;
  assign o_ctrl      = m_ctrl_p0;
  assign o_data      = m_data_p0;
  assign o_regs      = m_regs_p0;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (CNT_W = 4); adapts o_ready expectations to PIPE_SKID_EN.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [8:0]  c;
    logic [95:0] d;
    logic [14:0] r;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, o_valid, i_ready, i_flush, i_clr_cnt;
  logic [8:0]  i_ctrl, o_ctrl;
  logic [95:0] i_data, o_data;
  logic [14:0] i_regs, o_regs;
  logic [3:0]  o_stall_cnt;

  int   total = 0;
  int   bad   = 0;
  ent_t sbq[$];
  ent_t ex;

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(32), .NUM_DATA(3), .REG_W(5), .NUM_REG(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl),
    .i_data(i_data), .i_regs(i_regs), .o_valid(o_valid), .i_ready(i_ready),
    .o_ctrl(o_ctrl), .o_data(o_data), .o_regs(o_regs), .i_flush(i_flush),
    .i_clr_cnt(i_clr_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input int v, input logic [8:0] c);
    ent_t e;
    logic [31:0] w;
    w   = v;
    e.c = c;
    e.d = {~w, w + 32'd100, w};
    e.r = {5'(v + 2), 5'(v + 1), 5'(v)};
    return e;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; entered and left at 1 time unit after a rising edge.
  task automatic cyc(input logic v, input int val, input logic [8:0] c, input logic rdy,
                     input logic fl, input logic clr, input int exp_rdy);
    ent_t e;
    e = mk(val, c);
    i_valid = v;
    {i_ctrl, i_data, i_regs} = e;
    i_ready   = rdy;
    i_flush   = fl;
    i_clr_cnt = clr;
    #3;
    if (exp_rdy >= 0) check("o_ready", {127'd0, o_ready}, 128'(exp_rdy));
    if (fl) sbq.delete();
    else if (v && o_ready) sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data %0h expected no output", o_data);
        end else begin
          ex = sbq.pop_front();
          check("out_ctrl", 128'(o_ctrl), 128'(ex.c));
          check("out_data", 128'(o_data), 128'(ex.d));
          check("out_regs", 128'(o_regs), 128'(ex.r));
        end
      end
      if (!o_valid) check("bubble_ctrl", 128'(o_ctrl), 128'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_clr_cnt = 1'b0;
    i_ctrl = '0; i_data = '0; i_regs = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_ctrl",  128'(o_ctrl), 128'd0);
    check("rst_data",  128'(o_data), 128'd0);
    check("rst_regs",  128'(o_regs), 128'd0);
    check("rst_cnt",   128'(o_stall_cnt), 128'd0);
    check("rst_ready", 128'(o_ready), 128'd1);
    @(posedge clk); #1;

    // streaming at full rate
    cyc(1, 1, 9'h011, 1, 0, 0, 1);
    cyc(1, 2, 9'h022, 1, 0, 0, 1);
    cyc(1, 3, 9'h033, 1, 0, 0, 1);
    check("stream_word0", 128'(o_data[31:0]), 128'd3);
    cyc(0, 0, 9'h000, 1, 0, 0, 1);
    check("stream_cnt", 128'(o_stall_cnt), 128'd0);
    check("stream_drain", 128'(sbq.size()), 128'd0);

    // back-pressure: A, B, C with three stalled cycles
`ifdef PIPE_SKID_EN
    cyc(1, 10, 9'h0A0, 1, 0, 0, 1);
    cyc(1, 11, 9'h0B0, 0, 0, 0, 1);
    cyc(1, 12, 9'h0C0, 0, 0, 0, 0);
    cyc(1, 12, 9'h0C0, 0, 0, 0, 0);
    cyc(1, 12, 9'h0C0, 1, 0, 0, 0);
    cyc(1, 12, 9'h0C0, 1, 0, 0, 1);
    cyc(0, 0, 9'h000, 1, 0, 0, 1);
`else
    cyc(1, 10, 9'h0A0, 1, 0, 0, 1);
    cyc(1, 11, 9'h0B0, 0, 0, 0, 0);
    cyc(1, 11, 9'h0B0, 0, 0, 0, 0);
    cyc(1, 11, 9'h0B0, 0, 0, 0, 0);
    cyc(1, 11, 9'h0B0, 1, 0, 0, 1);
    cyc(1, 12, 9'h0C0, 1, 0, 0, 1);
    cyc(0, 0, 9'h000, 1, 0, 0, 1);
`endif
    check("bp_cnt", 128'(o_stall_cnt), 128'd3);
    check("bp_drain", 128'(sbq.size()), 128'd0);

    // flush with a new input offered in the same cycle
    cyc(1, 20, 9'h1FF, 1, 0, 1, 1);
    check("fl_full_ctrl", 128'(o_ctrl), 128'h1FF);
`ifdef PIPE_SKID_EN
    cyc(1, 21, 9'h1FF, 0, 0, 0, 1);
    check("fl_skid_ready", 128'(o_ready), 128'd0);
`endif
    cyc(1, 22, 9'h0AB, 0, 1, 0, -1);
    check("fl_valid", 128'(o_valid), 128'd0);
    check("fl_ctrl",  128'(o_ctrl), 128'd0);
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    #1;
    check("fl_ready", 128'(o_ready), 128'd1);
    @(posedge clk); #1;
    check("fl_still_empty", 128'(o_valid), 128'd0);

    // stall counter saturation and clear-over-increment
    cyc(1, 30, 9'h033, 1, 0, 1, 1);
    for (int k = 0; k < 20; k++) cyc(0, 0, 9'h000, 0, 0, 0, -1);
    check("sat_cnt", 128'(o_stall_cnt), 128'd15);
    cyc(0, 0, 9'h000, 0, 0, 1, -1);
    check("clr_cnt", 128'(o_stall_cnt), 128'd0);
    check("sat_hold_valid", 128'(o_valid), 128'd1);
    cyc(0, 0, 9'h000, 1, 0, 0, 1);
    check("sat_drain", 128'(sbq.size()), 128'd0);

    // asynchronous reset mid-cycle with a stalled entry in flight
    cyc(1, 40, 9'h044, 1, 0, 0, 1);
    cyc(1, 41, 9'h055, 0, 0, 0, -1);
    i_valid = 1'b0; i_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 128'(o_valid), 128'd0);
    check("arst_ctrl",  128'(o_ctrl), 128'd0);
    check("arst_data",  128'(o_data), 128'd0);
    check("arst_regs",  128'(o_regs), 128'd0);
    check("arst_cnt",   128'(o_stall_cnt), 128'd0);
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_ready", 128'(o_ready), 128'd1);
    @(posedge clk); #1;
    cyc(1, 42, 9'h066, 1, 0, 0, 1);
    check("arst_word0", 128'(o_data[31:0]), 128'd42);
    cyc(0, 0, 9'h000, 1, 0, 0, 1);
    check("arst_drain", 128'(sbq.size()), 128'd0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed ID/EX-style latches between pipeline stages of the MIPS pipeline. It carries a control bundle and a data/register-index payload with valid/ready flow control, synchronous flush (bubble insertion), and an optional skid buffer that registers the upstream ready path. It also counts downstream back-pressure cycles for performance debug. One instance sits between each pair of adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `CTRL_W`, default 9: control bundle width (ALUSrc, ALUop[2:0], RegDst, MemRead, MemWrite, RegWrite, MemToReg).
- `DATA_W`, default 32: width of one data word.
- `NUM_DATA`, default 3: number of data words (data1, data2, imm).
- `REG_W`, default 5: register index width.
- `NUM_REG`, default 3: number of register indices (rs, rt, rd).
- `CNT_W`, default 16: stall counter width.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `i_valid`, in, 1: upstream entry valid.
- `o_ready`, out, 1: stage can accept an entry this cycle.
- `i_ctrl`, in, CTRL_W: upstream control bundle.
- `i_data`, in, DATA_W*NUM_DATA: upstream data words, word 0 in the LSBs.
- `i_regs`, in, REG_W*NUM_REG: upstream register indices, index 0 in the LSBs.
- `o_valid`, out, 1: downstream entry valid.
- `i_ready`, in, 1: downstream accepts the entry.
- `o_ctrl`, `o_data`, `o_regs`, out, same widths as the inputs: registered entry.
- `i_flush`, in, 1: synchronous flush (bubble).
- `i_clr_cnt`, in, 1: synchronous clear of the stall counter.
- `o_stall_cnt`, out, CNT_W: saturating back-pressure counter.

## Operation
- Transfer in: `i_valid && o_ready`. Transfer out: `o_valid && i_ready`.
- Main register (M) drives all outputs. `o_ctrl` is all-zero whenever `o_valid` = 0, so bubbles are inert downstream.
- State machine, with skid enabled:
  - EMPTY: `o_valid` = 0. On transfer in, load M and go to FULL.
  - FULL:
    - `i_ready` && `i_valid`: reload M, stay in FULL.
    - `i_ready` && !`i_valid`: go to EMPTY.
    - !`i_ready` && `i_valid`: capture the input in the skid register (S), go to SKID.
    - !`i_ready` && !`i_valid`: hold.
  - SKID: `o_ready` = 0. On `i_ready`, M takes S and the state goes to FULL. `i_valid` is ignored in SKID.
- Flush has the highest priority. M and S valid bits clear, `o_ctrl` clears, and the state goes to EMPTY. An input offered in the same cycle is dropped. Data and register fields hold (don't-care).
- Stall counter increments each cycle with `o_valid` && !`i_ready`. It saturates at 2^CNT_W−1 and does not wrap.
  - `i_clr_cnt` zeroes it and wins over increment.
  - Flush does not affect it.
- Reset: state EMPTY; `o_valid`, `o_ctrl`, `o_data`, `o_regs`, `o_stall_cnt` and S all zero; `o_ready` = 1 after reset deasserts.
- Reset asserted mid-operation discards M and S immediately, asynchronously.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on the outputs after edge N.
- Throughput is 1 entry/cycle while `i_ready` = 1.
- With skid, `o_ready` is a pure register output (`!S.valid`), with no combinational path from `i_ready`.
- Without skid, `o_ready = !o_valid || i_ready` (combinational).
- Flush takes effect at the next edge; `o_valid` = 0 the cycle after flush is sampled.
- Stall counter is updated at the same edge as the stalled cycle it records.

## Configuration
- `PIPE_SKID_EN`
  - Defined: skid register S and the SKID state are compiled in; `o_ready` is registered.
  - Undefined: S is removed and only EMPTY/FULL exist. The !`i_ready` && `i_valid` case in FULL cannot occur, because `o_ready` = 0 then.

## Test plan
- Reset then stream: `i_valid` = 1 with `i_data` word0 = 1, 2, 3 on consecutive cycles, `i_ready` = 1 → `o_data` word0 = 1, 2, 3 one cycle later each; `o_stall_cnt` = 0.
- Back-pressure with skid: stream A, B, C with `i_ready` = 0 from A's output cycle.
  - `o_valid` = 1 holding A; B is captured in S; `o_ready` = 0 the next cycle; C is held upstream.
  - Raise `i_ready` → A, B, C are delivered in order with no loss or duplicate.
  - `o_stall_cnt` equals the number of stalled cycles.
- Flush: FULL or SKID state with `i_ctrl` = 9'h1FF, assert `i_flush` with a new valid input → next cycle `o_valid` = 0, `o_ctrl` = 0, state EMPTY, `o_ready` = 1, and the new input is not delivered.
- Counter saturation (CNT_W = 4): hold `o_valid` = 1 and `i_ready` = 0 for 20 cycles → `o_stall_cnt` = 15. Then assert `i_clr_cnt` with a stall in the same cycle → 0.
- Asynchronous reset: assert `rst` mid-cycle while in SKID state → outputs go to zero before the next clock edge; after release, one input transfers normally.
- Without `PIPE_SKID_EN`: FULL state with `i_ready` = 0 → `o_ready` = 0 in the same cycle; `i_ready` = 1 → `o_ready` = 1 combinationally, and back-to-back transfer works.
